// File: rtl/spart_rx_fifo_if.sv
// Bus-side signal bundle of the SPART receiver: read handshake, FIFO head and status.
// The master modport is the bus interface reading words; the slave modport is the receiver.
interface spart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                 rd_en;
    logic                 clr_ovr;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rda;
    logic                 overrun;
    logic [CW-1:0]        fifo_count;
    logic                 busy;

    modport master (
        output rd_en, clr_ovr,
        input  rx_data, rx_perr, rx_ferr, rda, overrun, fifo_count, busy
    );

    modport slave (
        input  rd_en, clr_ovr,
        output rx_data, rx_perr, rx_ferr, rda, overrun, fifo_count, busy
    );
endinterface

// File: rtl/spart_rx_fifo.sv
// Parametrised SPART receiver: oversampled start/data/parity/stop capture into a
// first-word-fall-through FIFO holding {perr, ferr, data} per received frame.
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               brg_en,
    input  logic               rxd,
    spart_rx_fifo_if.slave     host
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_BITS + 2;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n;
    logic                 armed, armed_n;
    logic                 sync1, rxd_s;
    logic                 wr_en, ferr_w;

    // rxd is asynchronous to clk; both stages idle high so reset looks like a quiet line
    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
            armed    <= 1'b1;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            perr     <= perr_n;
            armed    <= armed_n;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        perr_n  = perr;
        armed_n = armed;
        wr_en   = 1'b0;
        ferr_w  = 1'b0;
        if (brg_en) begin
            unique case (state)
                IDLE: begin
                    if (rxd_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_MID) begin
                        if (rxd_s) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                            perr_n  = 1'b0;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
                        tick_n  = '0;
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        perr_n  = ((^shreg) ^ rxd_s) != (PARITY_ODD != 0);
                        tick_n  = '0;
                        state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        ferr_w  = ~rxd_s;
                        wr_en   = 1'b1;
                        state_n = IDLE;
                        // a low stop bit may be a break: require the line high before re-arming
                        if (!rxd_s) armed_n = 1'b0;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovr;
    logic          full, empty, do_push, do_pop;
    logic [EW-1:0] head;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = host.rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    // NOTE: storage is not reset; an entry is only observable once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {perr, ferr_w, shreg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (wr_en && !do_push) ovr <= 1'b1;
            else if (host.clr_ovr) ovr <= 1'b0;
        end
    end

    assign head            = mem[rd_ptr];
    assign host.rda        = !empty;
    assign host.rx_data    = empty ? '0 : head[DATA_BITS-1:0];
    assign host.rx_ferr    = !empty && head[DATA_BITS];
    assign host.rx_perr    = !empty && head[DATA_BITS+1];
    assign host.overrun    = ovr;
    assign host.fifo_count = count;
    assign host.busy       = (state != IDLE);
endmodule

// File: tb/tb_spart_rx_fifo.sv
// Bench for spart_rx_fifo: an 8N1 unit and an 8E1 unit driven bit-serially,
// expected FIFO entries kept in queues and checked by per-unit pop monitors.
module tb_spart_rx_fifo;
    localparam int DB    = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic          perr;
        logic          ferr;
        logic [DB-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic brg_en = 1'b0;
    logic rxd_n = 1'b1;
    logic rxd_p = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t exp_n[$];
    ent_t exp_p[$];
    bit   ovr_n = 1'b0;
    bit   ovr_p = 1'b0;

    spart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus_n ();
    spart_rx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus_p ();

    spart_rx_fifo #(
        .DATA_BITS(DB), .PARITY_EN(0), .PARITY_ODD(0), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
    ) dut_n (
        .clk(clk), .rst(rst), .brg_en(brg_en), .rxd(rxd_n), .host(bus_n)
    );

    spart_rx_fifo #(
        .DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(0), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
    ) dut_p (
        .clk(clk), .rst(rst), .brg_en(brg_en), .rxd(rxd_p), .host(bus_p)
    );

    always #5 clk = ~clk;

    // brg_en is high on every 4th clock edge
    initial begin
        int phase = 0;
        forever begin
            @(negedge clk);
            phase  = (phase + 1) % 4;
            brg_en = (phase == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench did not complete in time");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // pop monitors: a read with data present must show the oldest expected entry
    always @(negedge clk) begin
        ent_t e;
        if (bus_n.rd_en === 1'b1) begin
            if (exp_n.size() > 0) begin
                e = exp_n.pop_front();
                check("head_n_rda", 32'(bus_n.rda), 1);
                check("head_n_entry", 32'({bus_n.rx_perr, bus_n.rx_ferr, bus_n.rx_data}), 32'(e));
            end else begin
                check("pop_empty_n", 32'({bus_n.rda, bus_n.rx_data}), 0);
            end
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (bus_p.rd_en === 1'b1) begin
            if (exp_p.size() > 0) begin
                e = exp_p.pop_front();
                check("head_p_rda", 32'(bus_p.rda), 1);
                check("head_p_entry", 32'({bus_p.rx_perr, bus_p.rx_ferr, bus_p.rx_data}), 32'(e));
            end else begin
                check("pop_empty_p", 32'({bus_p.rda, bus_p.rx_data}), 0);
            end
        end
    end

    function automatic int qsize(input int u);
        return (u == 0) ? exp_n.size() : exp_p.size();
    endfunction

    function automatic int dcount(input int u);
        return (u == 0) ? int'(bus_n.fifo_count) : int'(bus_p.fifo_count);
    endfunction

    function automatic logic drda(input int u);
        return (u == 0) ? bus_n.rda : bus_p.rda;
    endfunction

    function automatic logic dovr(input int u);
        return (u == 0) ? bus_n.overrun : bus_p.overrun;
    endfunction

    task automatic set_line(input int u, input logic v);
        if (u == 0) rxd_n = v;
        else        rxd_p = v;
    endtask

    task automatic set_rd(input int u, input logic v);
        if (u == 0) bus_n.rd_en = v;
        else        bus_p.rd_en = v;
    endtask

    // returns 1 ns after the n-th following brg_en edge
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!brg_en) @(posedge clk);
        end
        #1;
    endtask

    task automatic idle(input int u, input int n);
        set_line(u, 1'b1);
        wait_ticks(n);
    endtask

    task automatic check_zero_outputs();
        check("rst_outputs_n", 32'({bus_n.rx_data, bus_n.rx_perr, bus_n.rx_ferr, bus_n.rda,
                                    bus_n.overrun, bus_n.fifo_count, bus_n.busy}), 0);
        check("rst_outputs_p", 32'({bus_p.rx_data, bus_p.rx_perr, bus_p.rx_ferr, bus_p.rda,
                                    bus_p.overrun, bus_p.fifo_count, bus_p.busy}), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_zero_outputs();
        exp_n.delete();
        exp_p.delete();
        ovr_n = 1'b0;
        ovr_p = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_read(input int u);
        set_rd(u, 1'b1);
        @(posedge clk);
        #1;
        set_rd(u, 1'b0);
        check("read_count", 32'(dcount(u)), 32'(qsize(u)));
        check("read_rda", 32'(drda(u)), 32'(qsize(u) > 0));
    endtask

    task automatic do_clr_ovr(input int u);
        if (u == 0) bus_n.clr_ovr = 1'b1;
        else        bus_p.clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        bus_n.clr_ovr = 1'b0;
        bus_p.clr_ovr = 1'b0;
        if (u == 0) ovr_n = 1'b0;
        else        ovr_p = 1'b0;
        check("clr_ovr", 32'(dovr(u)), 0);
    endtask

    // Sends one frame; unit 1 carries a parity bit. The stop sample lands 9 ticks
    // into the stop bit (start edge seen 1 tick late, mid-bit at OS/2 ticks).
    // abort_bit >= 0 resets the DUTs halfway through that data bit instead.
    task automatic send_frame(input int u, input logic [DB-1:0] d, input logic pbit,
                              input logic stop, input bit pop_at_stop, input int abort_bit);
        ent_t e;
        wait_ticks(1);
        set_line(u, 1'b0);
        wait_ticks(OS);
        for (int k = 0; k < DB; k++) begin
            set_line(u, d[k]);
            if (k == abort_bit) begin
                wait_ticks(OS / 2);
                do_reset();
                set_line(u, 1'b1);
                wait_ticks(2 * OS);
                return;
            end
            wait_ticks(OS);
        end
        if (u == 1) begin
            set_line(u, pbit);
            wait_ticks(OS);
        end
        set_line(u, stop);
        wait_ticks(OS / 2);
        repeat (3) @(posedge clk);
        #1;
        check("pre_stop_count", 32'(dcount(u)), 32'(qsize(u)));
        if (pop_at_stop) set_rd(u, 1'b1);
        @(posedge clk);
        #1;
        set_rd(u, 1'b0);
        e.data = d;
        e.ferr = ~stop;
        e.perr = (u == 1) && ((($countones(d) + int'(pbit)) % 2) != 0);
        if (qsize(u) < DEPTH) begin
            if (u == 0) exp_n.push_back(e);
            else        exp_p.push_back(e);
        end else begin
            if (u == 0) ovr_n = 1'b1;
            else        ovr_p = 1'b1;
        end
        check("post_stop_count", 32'(dcount(u)), 32'(qsize(u)));
        check("post_stop_rda", 32'(drda(u)), 32'(qsize(u) > 0));
        check("post_stop_overrun", 32'(dovr(u)), 32'((u == 0) ? ovr_n : ovr_p));
        wait_ticks(OS / 2 - 1);
    endtask

    task automatic drain(input int u);
        while (qsize(u) > 0) do_read(u);
    endtask

    initial begin
        bit busy_seen;
        bus_n.rd_en = 1'b0;
        bus_n.clr_ovr = 1'b0;
        bus_p.rd_en = 1'b0;
        bus_p.clr_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs();
        rst = 1'b0;
        idle(0, 4);

        // single 8N1 frame, then one read empties the FIFO
        send_frame(0, 8'h6a, 1'b0, 1'b1, 0, -1);
        idle(0, 2);
        do_read(0);

        // 4-tick glitch on an idle line is rejected at the mid-bit check
        wait_ticks(1);
        set_line(0, 1'b0);
        wait_ticks(4);
        set_line(0, 1'b1);
        check("glitch_busy_start", 32'(bus_n.busy), 1);
        wait_ticks(4);
        check("glitch_busy_hold", 32'(bus_n.busy), 1);
        wait_ticks(1);
        check("glitch_busy_end", 32'(bus_n.busy), 0);
        check("glitch_no_write", 32'({bus_n.rda, bus_n.fifo_count}), 0);
        idle(0, 8);

        // even parity: wrong then correct parity bit
        send_frame(1, 8'hf3, 1'b1, 1'b1, 0, -1);
        idle(1, 4);
        send_frame(1, 8'hf3, 1'b0, 1'b1, 0, -1);
        idle(1, 4);
        drain(1);

        // framing error followed by a held-low line: no new frame until high
        send_frame(0, 8'h55, 1'b0, 1'b0, 0, -1);
        busy_seen = 1'b0;
        for (int i = 0; i < OS; i++) begin
            wait_ticks(1);
            if (bus_n.busy) busy_seen = 1'b1;
        end
        check("break_no_restart", 32'(busy_seen), 0);
        check("break_count", 32'(bus_n.fifo_count), 1);
        idle(0, 8);
        check("break_idle_busy", 32'(bus_n.busy), 0);
        drain(0);

        // overrun on a 5th unread frame, then the same with a pop on the write cycle
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, DB'(i), 1'b0, 1'b1, 0, -1);
            idle(0, 3);
        end
        check("full_count", 32'(bus_n.fifo_count), DEPTH);
        check("full_overrun", 32'(bus_n.overrun), 1);
        drain(0);
        do_clr_ovr(0);
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, DB'(i), 1'b0, 1'b1, (i == 5), -1);
            idle(0, 3);
        end
        check("pop_write_overrun", 32'(bus_n.overrun), 0);
        check("pop_write_count", 32'(bus_n.fifo_count), DEPTH);
        drain(0);
        do_read(0);

        // reset in the middle of data bit 3 discards the frame and the FIFO
        send_frame(0, 8'h11, 1'b0, 1'b1, 0, -1);
        idle(0, 4);
        send_frame(0, 8'ha5, 1'b0, 1'b1, 0, 3);
        check("after_rst_empty", 32'({bus_n.rda, bus_n.fifo_count, bus_n.busy}), 0);
        send_frame(0, 8'h3c, 1'b0, 1'b1, 0, -1);
        idle(0, 2);
        drain(0);

        // randomized frames on both units with random reads
        for (int i = 0; i < 14; i++) begin
            int u;
            u = int'($urandom_range(0, 1));
            send_frame(u, DB'($urandom), 1'($urandom), ($urandom_range(0, 5) != 0), 0, -1);
            idle(u, int'($urandom_range(2, 12)));
            repeat ($urandom_range(0, 2)) do_read(u);
        end
        drain(0);
        drain(1);
        check("final_overrun_n", 32'(bus_n.overrun), 32'(ovr_n));
        check("final_overrun_p", 32'(bus_p.overrun), 32'(ovr_p));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
